bitrev_reorder: RTL
===================

BITREV_REORDER -- requirements
Module: bitrev_reorder

Interface
REQ-001 SHALL have parameter N, default 8, FFT frame length in points (power of 2, 4..1024).
REQ-002 SHALL have parameter width, default 12, signed bit width of each real/imag component.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1: input sample present this cycle.
REQ-006 SHALL have ports in_re / in_im, input, width, signed: FFT output sample, arriving in bit-reversed index order.
REQ-007 SHALL have port out_valid, output, 1: out_re/out_im hold a valid natural-order sample.
REQ-008 SHALL have ports out_re / out_im, output, width, signed: reordered sample.
REQ-009 SHALL have port out_last, output, 1: high with the final sample (index N-1) of each frame.
REQ-010 SHALL have port overflow, output, 1: sticky error flag.

Function
REQ-011 SHALL hold two banks (ping-pong) of N complex words each.
REQ-012 SHALL keep a write counter wcnt (log2 N bits) and a write-bank select wbank; each in_valid cycle writes the sample to address bitrev(wcnt) of bank wbank, then increments wcnt.
REQ-013 SHALL, on the in_valid cycle with wcnt = N-1, set full[wbank], wrap wcnt to 0 and toggle wbank in the same edge.
REQ-014 SHALL treat in_valid low as a stall: wcnt, wbank and bank contents are unchanged; gaps inside a frame are legal.
REQ-015 SHALL run a read FSM with states IDLE and READ; IDLE -> READ when full of the bank selected by rbank is set; READ -> IDLE after index N-1 is issued unless the other bank is already full.
REQ-016 SHALL, in READ, issue natural-order addresses 0..N-1 of bank rbank, one per cycle, with no gaps.
REQ-017 SHALL register the read data: out_valid is high exactly N consecutive cycles per frame, and the first output appears 2 cycles after the edge that captured the frame's final input.
REQ-018 SHALL, on issuing address N-1, clear full[rbank] and toggle rbank; if the other bank is full, READ continues with address 0 on the next cycle (back-to-back frames, no bubble).
REQ-019 SHALL assert out_last only alongside out_valid for index N-1.
REQ-020 SHALL hold out_re/out_im at their last value and out_valid=0 when no sample is issued.
REQ-021 SHALL set overflow when a write targets a bank whose full flag is still set; that write is dropped. overflow is cleared only by rst.
REQ-022 SHALL permit a simultaneous frame completion on the write side and a final read on the other bank in the same cycle without loss or a false overflow.
REQ-023 SHALL sustain continuous in_valid=1 indefinitely without overflow.

Reset
REQ-024 SHALL, while rst=1, clear wcnt, wbank, rbank, the read address, both full flags, out_valid, out_last, overflow, out_re and out_im (to 0), and force the FSM to IDLE.
REQ-025 SHALL discard any partial frame on a mid-frame rst; bank contents need not be cleared.
REQ-026 SHALL accept a sample with in_valid=1 on the first cycle after rst deasserts as frame index 0.

Structure
REQ-027 SHALL take log2 helper, bitrev(index, bits) function and FSM state encoding from shared package fft_pkg.
REQ-028 SHALL instantiate one sub-module, bitrev_ram: one write port and one registered read port, 2N words of 2*width bits.
REQ-029 SHALL contain all counters, flags and the FSM in bitrev_reorder itself.

Verification
REQ-030 SHALL cover N=8 with one frame of re = 0..7 in arrival order (im = -re) -> output re order 0,4,2,6,1,5,3,7, im negated, out_last on 7, first out_valid 2 cycles after the final input.
REQ-031 SHALL cover continuous in_valid for 4 frames -> 32 contiguous out_valid cycles, correct order in every frame, overflow=0.
REQ-032 SHALL cover in_valid toggling 1,0,1,0 within a frame -> identical output to the unstalled case; output starts 2 cycles after the 8th accepted sample.
REQ-033 SHALL cover writing 3 frames back-to-back while the first read is blocked by forced overlap (stalled harness) -> overflow=1 sticky, third frame dropped.
REQ-034 SHALL cover rst asserted after 5 samples, then a full new frame -> output equals the new frame only; no out_valid during or right after rst.
REQ-035 SHALL cover signed extremes (-2048, 2047 for width=12) -> passed through bit-exact.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FFT helpers: index-width and bit-reversal functions plus the reorder read FSM encoding.
package fft_pkg;

  typedef enum logic {StIdle, StRead} rd_state_e;

  // Smallest r with 2**r >= n; used as an elaboration-time constant.
  function automatic int unsigned log2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 31; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Reverse the low 'bits' bits of index; upper bits of the result are zero.
  function automatic logic [31:0] bitrev(input logic [31:0] index, input int unsigned bits);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < bits) r = r | (((index >> (bits - 1 - i)) & 32'd1) << i);
    end
    return r;
  endfunction

endpackage

// File: rtl/bitrev_ram.sv
// Simple dual-port storage for both ping-pong banks: one write port, one registered read port.
module bitrev_ram #(
  parameter int unsigned Depth = 16,
  parameter int unsigned Width = 24,
  parameter int unsigned AddrW = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Read register holds its value between reads, so the output stays stable when idle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/bitrev_reorder.sv
// Converts FFT output from bit-reversed to natural order using two ping-pong frame banks.
module bitrev_reorder
  import fft_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned width = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic signed [width-1:0] in_re,
  input  logic signed [width-1:0] in_im,
  output logic                    out_valid,
  output logic signed [width-1:0] out_re,
  output logic signed [width-1:0] out_im,
  output logic                    out_last,
  output logic                    overflow
);

  localparam int unsigned AW = log2(N);

  rd_state_e       state_q, state_d;
  logic [AW-1:0]   wcnt_q, wcnt_d;
  logic [AW-1:0]   raddr_q, raddr_d;
  logic            wbank_q, wbank_d;
  logic            rbank_q, rbank_d;
  logic [1:0]      full_q, full_d;
  logic            overflow_q, overflow_d;
  logic            out_valid_q, out_last_q;

  logic            rd_issue, rd_final, wr_free, wr_en, wr_final;
  logic [AW:0]     waddr, raddr;
  logic [2*width-1:0] ram_rdata;

  always_comb begin
    rd_issue = (state_q == StRead);
    rd_final = rd_issue && (raddr_q == AW'(N - 1));
    // A bank whose last word is being read this cycle is free to be written already.
    wr_free  = !full_q[wbank_q] || (rd_final && (rbank_q == wbank_q));
    wr_en    = in_valid && wr_free;
    wr_final = in_valid && (wcnt_q == AW'(N - 1));
    waddr    = {wbank_q, AW'(bitrev(32'(wcnt_q), AW))};
    raddr    = {rbank_q, raddr_q};
  end

  // Dropped writes still advance wcnt/wbank so frame alignment is kept.
  always_comb begin
    wcnt_d     = in_valid ? wcnt_q + AW'(1) : wcnt_q;
    wbank_d    = wbank_q ^ wr_final;
    raddr_d    = rd_issue ? raddr_q + AW'(1) : raddr_q;
    rbank_d    = rbank_q ^ rd_final;
    overflow_d = overflow_q | (in_valid && !wr_free);
    full_d     = full_q;
    if (rd_final) full_d[rbank_q] = 1'b0;
    if (wr_final && wr_en) full_d[wbank_q] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (full_q[rbank_q]) state_d = StRead;
      StRead: if (rd_final && !full_q[~rbank_q]) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      wcnt_q      <= '0;
      raddr_q     <= '0;
      wbank_q     <= 1'b0;
      rbank_q     <= 1'b0;
      full_q      <= '0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      raddr_q     <= raddr_d;
      wbank_q     <= wbank_d;
      rbank_q     <= rbank_d;
      full_q      <= full_d;
      overflow_q  <= overflow_d;
      out_valid_q <= rd_issue;
      out_last_q  <= rd_final;
    end
  end

  bitrev_ram #(
    .Depth(2 * N),
    .Width(2 * width),
    .AddrW(AW + 1)
  ) u_ram (
    .clk_i  (clk),
    .rst_i  (rst),
    .we_i   (wr_en),
    .waddr_i(waddr),
    .wdata_i({in_re, in_im}),
    .re_i   (rd_issue),
    .raddr_i(raddr),
    .rdata_o(ram_rdata)
  );

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign overflow  = overflow_q;
  assign out_re    = ram_rdata[2*width-1:width];
  assign out_im    = ram_rdata[width-1:0];

endmodule
